// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential double-dabble BCD converter.
// Optional blanking output is enabled with BCD_CTRL_BLANK_EN.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef logic [3:0] digit_t;

    localparam digit_t BCD_ADJ_THRESH = 4'd5;
    localparam digit_t BCD_ADJ        = 4'd3;

endpackage

// File: rtl/bcd_convert_ctrl_if.sv
// Start/busy/done handshake and result bus for bcd_convert_ctrl.
// Carries the blank vector only when BCD_CTRL_BLANK_EN is defined.
interface bcd_convert_ctrl_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic                  sign;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;
`ifdef BCD_CTRL_BLANK_EN
    logic [DIGITS-1:0]     blank;
`endif

    modport master (
`ifdef BCD_CTRL_BLANK_EN
        input  blank,
`endif
        output start, bin,
        input  busy, done, sign, bcd, ovf
    );

    modport slave (
`ifdef BCD_CTRL_BLANK_EN
        output blank,
`endif
        input  start, bin,
        output busy, done, sign, bcd, ovf
    );
endinterface

// File: rtl/bcd_dabble_digit.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_dabble_digit
    import bcd_pkg::*;
(
    input  digit_t din,
    output digit_t dout
);
    assign dout = (din >= BCD_ADJ_THRESH) ? digit_t'(din + BCD_ADJ) : din;
endmodule

// File: rtl/bcd_convert_ctrl.sv
// Sequential two's-complement to sign+BCD converter, one bit per clock.
// Define BCD_CTRL_BLANK_EN to add the registered leading-zero blank vector.
module bcd_convert_ctrl
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_convert_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t                 state;
    digit_t [DIGITS-1:0]    dig_q;
    digit_t [DIGITS-1:0]    dig_adj;
    logic [4*DIGITS-1:0]    adj_flat;
    logic [4*DIGITS-1:0]    dig_shift;
    logic [WIDTH-1:0]       mag_q;
    logic [CW-1:0]          cnt_q;
    logic                   ovf_q;
    logic                   sign_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_dabble_digit u_dig (
            .din  (dig_q[g]),
            .dout (dig_adj[g])
        );
    end

    // Magnitude MSB enters digit 0; the top digit's bit 3 falls off as overflow.
    assign adj_flat  = dig_adj;
    assign dig_shift = {adj_flat[4*DIGITS-2:0], mag_q[WIDTH-1]};

`ifdef BCD_CTRL_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    for (genvar g = 0; g < DIGITS; g++) begin : g_blank
        if (g == 0) begin : g_lsd
            assign blank_nxt[g] = 1'b0;
        end else begin : g_hi
            assign blank_nxt[g] = (dig_q[DIGITS-1:g] == '0);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dig_q    <= '0;
            mag_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            sign_q   <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sign <= 1'b0;
            bus.bcd  <= '0;
            bus.ovf  <= 1'b0;
`ifdef BCD_CTRL_BLANK_EN
            bus.blank <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.busy <= 1'b0;
                    if (bus.start) begin
                        sign_q   <= bus.bin[WIDTH-1];
                        mag_q    <= bus.bin[WIDTH-1] ? (~bus.bin + WIDTH'(1)) : bus.bin;
                        dig_q    <= '0;
                        cnt_q    <= CW'(WIDTH);
                        ovf_q    <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    dig_q <= dig_shift;
                    mag_q <= {mag_q[WIDTH-2:0], 1'b0};
                    ovf_q <= ovf_q | adj_flat[4*DIGITS-1];
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1))
                        state <= DONE;
                end
                DONE: begin
                    bus.bcd  <= dig_q;
                    bus.sign <= sign_q;
                    bus.ovf  <= ovf_q;
`ifdef BCD_CTRL_BLANK_EN
                    bus.blank <= blank_nxt;
`endif
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
